// File: rtl/ecg_sample_feeder.sv
// ecg_sample_feeder: assembles little-endian byte pairs into offset-binary
// ECG samples, converts them to signed, buffers them in a small FIFO and
// releases them to the detection core at a paced rate.
module ecg_sample_feeder #(
    parameter int DATA_WIDTH  = 11,
    parameter int DATA_OFFSET = 1024,
    parameter int FIFO_DEPTH  = 8,
    parameter int SAMPLE_DIV  = 4
) (
    input  logic                         i_clk,
    input  logic                         i_nrst,
    input  logic                         i_ce,
    input  logic [7:0]                   i_byte,
    input  logic                         i_byte_valid,
    output logic                         o_byte_ready,
    input  logic                         i_flush,
    output logic signed [DATA_WIDTH-1:0] o_ecg_value,
    output logic                         o_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_level,
    output logic                         o_format_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(SAMPLE_DIV) + 1;

    localparam logic [PW-1:0]         PACER_RELOAD = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]         FULL_LEVEL   = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] OFFSET_V     = DATA_WIDTH'(DATA_OFFSET);
    // High-byte bits that must be zero for a legal sample (none when DATA_WIDTH = 16).
    localparam logic [7:0]            HI_BAD_MASK  = 8'hFF << (DATA_WIDTH - 8);

    typedef enum logic [0:0] {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } asm_state_t;

    asm_state_t state_q, state_d;

    logic [7:0]            low_q, low_d;
    logic                  err_q, err_d;
    logic [CW-1:0]         count_q, count_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         pacer_q, pacer_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic                  full_s;
    logic                  accept_s;
    logic                  flush_s;
    logic                  pop_s;
    logic                  hi_bad_s;
    logic                  latch_low_s;
    logic                  push_s;
    logic                  fmt_bad_s;
    logic [DATA_WIDTH-1:0] raw_s;
    logic [DATA_WIDTH-1:0] sample_s;

    assign full_s       = (count_q == FULL_LEVEL);
    assign o_byte_ready = !full_s && !i_flush;
    assign accept_s     = i_ce && i_byte_valid && o_byte_ready;
    assign flush_s      = i_ce && i_flush;
    assign pop_s        = i_ce && !i_flush && (pacer_q == {PW{1'b0}}) && (count_q != {CW{1'b0}});
    assign hi_bad_s     = |(i_byte & HI_BAD_MASK);
    // Truncating {high, low} keeps byte[DATA_WIDTH-9:0] above the latched low byte.
    assign raw_s        = DATA_WIDTH'({i_byte, low_q});
    assign sample_s     = raw_s - OFFSET_V;

    assign o_ecg_value  = value_q;
    assign o_data_valid = valid_q;
    assign o_fifo_level = count_q;
    assign o_format_err = err_q;

    // Assembler state register.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    // Assembler next state: toggle LOW/HIGH on every accepted byte, flush returns to LOW.
    always_comb begin
        state_d = state_q;
        if (flush_s) begin
            state_d = ST_LOW;
        end else if (accept_s) begin
            case (state_q)
                ST_LOW:  state_d = ST_HIGH;
                ST_HIGH: state_d = ST_LOW;
                default: state_d = ST_LOW;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Assembler outputs: latch the low byte, or complete the sample (push or reject).
    always_comb begin
        latch_low_s = 1'b0;
        push_s      = 1'b0;
        fmt_bad_s   = 1'b0;
        if (accept_s && !flush_s) begin
            case (state_q)
                ST_LOW: latch_low_s = 1'b1;
                ST_HIGH: begin
                    if (hi_bad_s) begin
                        fmt_bad_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end
                default: latch_low_s = 1'b0;
            endcase
        end else begin
            latch_low_s = 1'b0;
        end
    end

    // Datapath next values: low byte, error flag, FIFO bookkeeping, pacer and output strobe.
    always_comb begin
        low_d    = low_q;
        err_d    = err_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        pacer_d  = pacer_q;
        valid_d  = valid_q;
        value_d  = value_q;

        if (latch_low_s) begin
            low_d = i_byte;
        end else begin
            low_d = low_q;
        end

        if (flush_s) begin
            err_d    = 1'b0;
            count_d  = {CW{1'b0}};
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            pacer_d  = {PW{1'b0}};
            valid_d  = 1'b0;
        end else if (i_ce) begin
            if (fmt_bad_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end

            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end

            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase

            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
                value_d  = mem_q[rd_ptr_q];
                pacer_d  = PACER_RELOAD;
                valid_d  = 1'b1;
            end else begin
                valid_d = 1'b0;
                if (pacer_q != {PW{1'b0}}) begin
                    pacer_d = pacer_q - PW'(1'b1);
                end else begin
                    pacer_d = pacer_q;
                end
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Datapath and FIFO control registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            low_q    <= 8'h00;
            err_q    <= 1'b0;
            count_q  <= {CW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            pacer_q  <= {PW{1'b0}};
            valid_q  <= 1'b0;
            value_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            low_q    <= low_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            pacer_q  <= pacer_d;
            valid_q  <= valid_d;
            value_q  <= value_d;
        end
    end

    // FIFO storage: write the converted sample at the write pointer on a push.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= sample_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

endmodule

// File: tb/tb_ecg_sample_feeder.sv
// Self-checking bench for ecg_sample_feeder: directed scenarios plus a
// randomized run compared against a queue-based behavioural model.
module tb_ecg_sample_feeder;

    localparam int DW    = 11;
    localparam int OFFS  = 1024;
    localparam int DEPTH = 8;
    localparam int DIV   = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk    = 1'b0;
    logic                 rst_n  = 1'b1;
    logic                 ce     = 1'b0;
    logic [7:0]           bbyte  = 8'h00;
    logic                 bvalid = 1'b0;
    logic                 flush  = 1'b0;
    logic                 ready;
    logic signed [DW-1:0] ecg;
    logic                 dvalid;
    logic [LW-1:0]        level;
    logic                 ferr;

    always #5 clk = ~clk;

    ecg_sample_feeder #(
        .DATA_WIDTH (DW),
        .DATA_OFFSET(OFFS),
        .FIFO_DEPTH (DEPTH),
        .SAMPLE_DIV (DIV)
    ) dut (
        .i_clk       (clk),
        .i_nrst      (rst_n),
        .i_ce        (ce),
        .i_byte      (bbyte),
        .i_byte_valid(bvalid),
        .o_byte_ready(ready),
        .i_flush     (flush),
        .o_ecg_value (ecg),
        .o_data_valid(dvalid),
        .o_fifo_level(level),
        .o_format_err(ferr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: a queue of signed samples plus a strobe cooldown.
    int mq[$];
    bit m_have_low;
    int m_low;
    bit m_err;
    int m_cool;
    bit m_valid;
    int m_value;

    int cyc = 0;
    int cecyc = 0;
    int ce_mode = 0;          // 0: ce held high, 1: ce toggles, 2: caller drives ce
    bit acc_last;
    int st_val[$];
    int st_cyc[$];
    int max_level;
    bit saw_not_ready;
    int full_pops;
    int full_pop_bad;

    task automatic model_reset();
        mq.delete();
        m_have_low = 0; m_low = 0; m_err = 0; m_cool = 0; m_valid = 0; m_value = 0;
    endtask

    task automatic model_edge();
        bit acc;
        bit pop;
        int hi;
        if (!ce) return;
        if (flush) begin
            mq.delete();
            m_have_low = 0; m_err = 0; m_cool = 0; m_valid = 0;
            return;
        end
        acc = bvalid && (mq.size() < DEPTH);
        pop = (m_cool == 0) && (mq.size() > 0);
        if (pop) begin
            m_value = mq.pop_front();
            m_valid = 1;
            m_cool  = DIV - 1;
        end else begin
            m_valid = 0;
            if (m_cool > 0) m_cool--;
        end
        if (acc) begin
            if (!m_have_low) begin
                m_low = int'(bbyte);
                m_have_low = 1;
            end else begin
                m_have_low = 0;
                hi = int'(bbyte);
                if (hi >= (1 << (DW - 8))) m_err = 1;
                else mq.push_back(hi * 256 + m_low - OFFS);
            end
        end
    endtask

    task automatic step();
        bit ce_e;
        bit was_full;
        if (ce_mode == 0) ce = 1'b1;
        else if (ce_mode == 1) ce = ~ce;
        #0;
        acc_last = ce && bvalid && ready;
        was_full = (mq.size() == DEPTH);
        @(posedge clk);
        ce_e = ce;
        model_edge();
        cyc++;
        if (ce_e) cecyc++;
        #1;
        if (ce_e && dvalid) begin
            st_val.push_back(int'(ecg));
            st_cyc.push_back(cecyc);
        end
        if (int'(level) > max_level) max_level = int'(level);
        if (!ready) saw_not_ready = 1;
        if (ce_e && was_full && !flush && dvalid) begin
            full_pops++;
            if (!ready) full_pop_bad++;
        end
    endtask

    task automatic idle(input int n);
        bvalid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        bit done = 0;
        bbyte  = b;
        bvalid = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            step();
            done = acc_last;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s_accept_timeout: accepted=0 required=1 byte=%02h", tag, b);
        end
    endtask

    task automatic send_sample(input int v, input string tag);
        int raw;
        raw = v + OFFS;
        send_byte(8'(raw), tag);
        send_byte(8'(raw >> 8), tag);
    endtask

    task automatic clear_obs();
        st_val.delete();
        st_cyc.delete();
    endtask

    task automatic test_reset();
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (ecg !== 11'sd0)     begin n_bad++; $display("FAIL reset_value: got %0d want 0", ecg); end
        n_cmp++; if (dvalid !== 1'b0)    begin n_bad++; $display("FAIL reset_valid: got %0b want 0", dvalid); end
        n_cmp++; if (level !== 4'd0)     begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (ferr !== 1'b0)      begin n_bad++; $display("FAIL reset_err: got %0b want 0", ferr); end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        n_cmp++; if (ready !== 1'b1)     begin n_bad++; $display("FAIL reset_ready: got %0b want 1", ready); end
        n_cmp++; if (dvalid !== 1'b0)    begin n_bad++; $display("FAIL reset_idle_valid: got %0b want 0", dvalid); end
    endtask

    task automatic test_conversion();
        int s_acc;
        int exp_v[3] = '{0, 1023, -1024};
        clear_obs();
        ce_mode = 0;
        send_byte(8'h00, "conv"); send_byte(8'h04, "conv");
        s_acc = cecyc;
        send_byte(8'hFF, "conv"); send_byte(8'h07, "conv");
        send_byte(8'h00, "conv"); send_byte(8'h00, "conv");
        idle(20);
        n_cmp++;
        if (st_val.size() != 3) begin
            n_bad++; $display("FAIL conv_count: got %0d strobes want 3", st_val.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (st_val[i] != exp_v[i]) begin
                    n_bad++; $display("FAIL conv_value[%0d]: got %0d want %0d", i, st_val[i], exp_v[i]);
                end
            end
            n_cmp++;
            if (st_cyc[0] != s_acc + 1) begin
                n_bad++; $display("FAIL conv_latency: strobe at ce-cycle %0d want %0d", st_cyc[0], s_acc + 1);
            end
        end
    endtask

    task automatic test_format_err();
        clear_obs();
        send_byte(8'h12, "fmt"); send_byte(8'h08, "fmt");
        idle(10);
        n_cmp++; if (st_val.size() != 0) begin n_bad++; $display("FAIL fmt_no_strobe: got %0d strobes want 0", st_val.size()); end
        n_cmp++; if (ferr !== 1'b1)      begin n_bad++; $display("FAIL fmt_err_set: got %0b want 1", ferr); end
        idle(10);
        n_cmp++; if (ferr !== 1'b1)      begin n_bad++; $display("FAIL fmt_err_sticky: got %0b want 1", ferr); end
        send_byte(8'h01, "fmt"); send_byte(8'h04, "fmt");
        idle(10);
        n_cmp++;
        if (st_val.size() != 1 || st_val[0] != 1) begin
            n_bad++; $display("FAIL fmt_next_sample: got %0d strobes first=%0d want 1 strobe of 1",
                              st_val.size(), (st_val.size() > 0) ? st_val[0] : 0);
        end
        n_cmp++; if (ferr !== 1'b1)      begin n_bad++; $display("FAIL fmt_err_kept: got %0b want 1", ferr); end
    endtask

    task automatic test_pacing();
        int v[3];
        for (int pass = 0; pass < 2; pass++) begin
            clear_obs();
            ce_mode = pass;
            for (int i = 0; i < 3; i++) begin
                v[i] = int'($urandom_range(0, 2047)) - OFFS;
                send_sample(v[i], "pace");
            end
            idle(40);
            ce_mode = 0;
            n_cmp++;
            if (st_val.size() != 3) begin
                n_bad++; $display("FAIL pace%0d_count: got %0d strobes want 3", pass, st_val.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    n_cmp++;
                    if (st_val[i] != v[i]) begin
                        n_bad++; $display("FAIL pace%0d_value[%0d]: got %0d want %0d", pass, i, st_val[i], v[i]);
                    end
                end
                for (int i = 1; i < 3; i++) begin
                    n_cmp++;
                    if (st_cyc[i] - st_cyc[i-1] != DIV) begin
                        n_bad++; $display("FAIL pace%0d_gap[%0d]: got %0d ce-cycles want %0d",
                                          pass, i, st_cyc[i] - st_cyc[i-1], DIV);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int gap_bad = 0;
        clear_obs();
        max_level = 0; saw_not_ready = 0; full_pops = 0; full_pop_bad = 0;
        for (int i = 0; i < 20; i++) send_sample(i, "bp");
        idle(120);
        n_cmp++; if (max_level != DEPTH) begin n_bad++; $display("FAIL bp_max_level: got %0d want %0d", max_level, DEPTH); end
        n_cmp++; if (!saw_not_ready)     begin n_bad++; $display("FAIL bp_ready_low: got never-low want low-when-full"); end
        n_cmp++;
        if (full_pops == 0 || full_pop_bad != 0) begin
            n_bad++; $display("FAIL bp_ready_after_pop: pops_from_full=%0d ready_low_after=%0d want >0 and 0",
                              full_pops, full_pop_bad);
        end
        n_cmp++;
        if (st_val.size() != 20) begin
            n_bad++; $display("FAIL bp_count: got %0d strobes want 20", st_val.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                n_cmp++;
                if (st_val[i] != i) begin
                    n_bad++; $display("FAIL bp_order[%0d]: got %0d want %0d", i, st_val[i], i);
                end
                if (i > 0 && st_cyc[i] - st_cyc[i-1] < DIV) gap_bad++;
            end
            n_cmp++;
            if (gap_bad != 0) begin n_bad++; $display("FAIL bp_spacing: %0d gaps under %0d want 0", gap_bad, DIV); end
        end
    endtask

    task automatic test_flush();
        idle(40);
        for (int i = 0; i < 6; i++) send_sample(int'($urandom_range(0, 2047)) - OFFS, "flush");
        send_byte(8'h55, "flush");
        n_cmp++; if (level !== 4'd3) begin n_bad++; $display("FAIL flush_pre_level: got %0d want 3", level); end
        bbyte = 8'hAA; bvalid = 1'b1; flush = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %0b want 0", ready); end
        step();
        flush = 1'b0; bvalid = 1'b0;
        n_cmp++; if (level !== 4'd0)  begin n_bad++; $display("FAIL flush_level: got %0d want 0", level); end
        n_cmp++; if (ferr !== 1'b0)   begin n_bad++; $display("FAIL flush_err: got %0b want 0", ferr); end
        n_cmp++; if (dvalid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %0b want 0", dvalid); end
        clear_obs();
        idle(20);
        n_cmp++; if (st_val.size() != 0) begin n_bad++; $display("FAIL flush_no_strobe: got %0d want 0", st_val.size()); end
        send_byte(8'h00, "flush"); send_byte(8'h04, "flush");
        idle(10);
        n_cmp++;
        if (st_val.size() != 1 || st_val[0] != 0) begin
            n_bad++; $display("FAIL flush_next_sample: got %0d strobes first=%0d want 1 strobe of 0",
                              st_val.size(), (st_val.size() > 0) ? st_val[0] : 0);
        end
    endtask

    task automatic test_reset_mid();
        idle(40);
        send_byte(8'h00, "rmid"); send_byte(8'hF0, "rmid");
        for (int i = 0; i < 10; i++) send_sample(100 + i, "rmid");
        send_byte(8'h33, "rmid");
        n_cmp++; if (level !== 4'd5) begin n_bad++; $display("FAIL rmid_pre_level: got %0d want 5", level); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (ecg !== 11'sd0)  begin n_bad++; $display("FAIL rmid_value: got %0d want 0", ecg); end
        n_cmp++; if (dvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %0b want 0", dvalid); end
        n_cmp++; if (level !== 4'd0)  begin n_bad++; $display("FAIL rmid_level: got %0d want 0", level); end
        n_cmp++; if (ferr !== 1'b0)   begin n_bad++; $display("FAIL rmid_err: got %0b want 0", ferr); end
        n_cmp++; if (ready !== 1'b1)  begin n_bad++; $display("FAIL rmid_ready: got %0b want 1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        send_byte(8'hFF, "rmid"); send_byte(8'h03, "rmid");
        idle(10);
        n_cmp++;
        if (st_val.size() != 1 || st_val[0] != -1) begin
            n_bad++; $display("FAIL rmid_next_sample: got %0d strobes first=%0d want 1 strobe of -1",
                              st_val.size(), (st_val.size() > 0) ? st_val[0] : 0);
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        ce_mode = 2;
        for (int i = 0; i < 800; i++) begin
            ce     = ($urandom_range(0, 3) != 0);
            flush  = ($urandom_range(0, 59) == 0);
            bvalid = ($urandom_range(0, 3) != 0);
            if (m_have_low) bbyte = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            else            bbyte = 8'($urandom);
            #1;
            exp_rdy = !flush && (mq.size() < DEPTH);
            n_cmp++;
            if (ready !== exp_rdy) begin
                n_bad++; $display("FAIL rand_ready@%0d: got %0b want %0b", i, ready, exp_rdy);
            end
            step();
            n_cmp++;
            if (dvalid !== m_valid || int'(level) != mq.size() || ferr !== m_err || int'(ecg) != m_value) begin
                n_bad++;
                $display("FAIL rand_outputs@%0d: got v=%0b lvl=%0d err=%0b val=%0d want v=%0b lvl=%0d err=%0b val=%0d",
                         i, dvalid, level, ferr, ecg, m_valid, mq.size(), m_err, m_value);
            end
        end
        flush = 1'b0; bvalid = 1'b0; ce_mode = 0;
    endtask

    initial begin
        test_reset();
        test_conversion();
        test_format_err();
        test_pacing();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
